// File: rtl/dmem_rd_pkg.sv
// Shared types and sizing helpers for the DMEM port-B line reader.
package dmem_rd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StShift,
      StFin
   } rd_state_e;

   localparam int unsigned LINE_W_DEF     = 256;
   localparam int unsigned WORD_W_DEF     = 16;
   localparam int unsigned WORDS_PER_LINE = LINE_W_DEF / WORD_W_DEF;
   localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_LINE);

   function automatic int unsigned words_per_line(input int unsigned line_w,
                                                  input int unsigned word_w);
      return line_w / word_w;
   endfunction

endpackage

// File: rtl/dmem_line_reader_if.sv
// DMEM port-B read path and outgoing word stream of the line reader.
interface dmem_line_reader_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned LINE_W = 256,
   parameter int unsigned WORD_W = 16
) ();

   logic              dmem_rden;
   logic [ADDR_W-1:0] dmem_rdaddr;
   logic [LINE_W-1:0] dmem_rddata;
   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   modport master (
      output dmem_rden, dmem_rdaddr, out_valid, out_data, out_last,
      input  dmem_rddata, out_ready
   );

   modport slave (
      input  dmem_rden, dmem_rdaddr, out_valid, out_data, out_last,
      output dmem_rddata, out_ready
   );

endinterface

// File: rtl/line_serializer.sv
// Holds one DMEM line and emits it LSB-first as WORD_W words on a valid/ready stream.
module line_serializer
   import dmem_rd_pkg::*;
#(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned WORD_W = 16,
   parameter int unsigned IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LINE_W-1:0] line,
   output logic              valid,
   output logic [WORD_W-1:0] data,
   input  logic              ready,
   output logic [IDX_W-1:0]  idx,
   output logic              last_word
);

   localparam int unsigned      Words   = words_per_line(LINE_W, WORD_W);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(Words - 1);

   logic [LINE_W-1:0] line_q, line_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;

   always_comb begin
      line_d  = line_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      // A load may coincide with the final transfer of the previous line.
      if (load) begin
         line_d  = line;
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (valid_q && ready) begin
         if (idx_q == LastIdx) begin
            valid_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         line_q  <= line_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign valid     = valid_q;
   assign data      = line_q[idx_q*WORD_W +: WORD_W];
   assign idx       = idx_q;
   assign last_word = (idx_q == LastIdx);

endmodule

// File: rtl/dmem_line_reader.sv
// Reads a run of DMEM port-B lines and streams them out as words.
// DMEM_RD_PREFETCH_EN adds a second line buffer so lines stream back to back.
module dmem_line_reader
   import dmem_rd_pkg::*;
#(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned LINE_W     = 256,
   parameter int unsigned WORD_W     = 16,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   line_cnt,
   output logic              busy,
   output logic              done,
   dmem_line_reader_if.master bus
);

   localparam int unsigned      Words   = words_per_line(LINE_W, WORD_W);
   localparam int unsigned      IdxW    = $clog2(Words);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(Words - 1);
   localparam logic [1:0]       LatCmp  = 2'(RD_LATENCY);
   localparam logic [ADDR_W:0]  RemOne  = (ADDR_W+1)'(1);

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic              rden_q, rden_d;
   logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
   logic              rd_pend_q, rd_pend_d;
   logic [1:0]        lat_q, lat_d;
`ifdef DMEM_RD_PREFETCH_EN
   logic [LINE_W-1:0] nxt_line_q, nxt_line_d;
   logic              nxt_full_q, nxt_full_d;
   logic              pf_done_q, pf_done_d;
`endif

   logic              rd_cap;
   logic              word_done;
   logic              ser_load;
   logic [LINE_W-1:0] ser_line;
   logic              ser_valid;
   logic [WORD_W-1:0] ser_data;
   logic [IdxW-1:0]   ser_idx;
   logic              ser_last_word;

   // rddata is valid RD_LATENCY cycles after the registered rden is visible.
   assign rd_cap    = rd_pend_q && (lat_q == LatCmp);
   assign word_done = ser_valid && bus.out_ready && ser_last_word;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      rden_d    = 1'b0;
      rdaddr_d  = rdaddr_q;
      rd_pend_d = rd_pend_q;
      lat_d     = lat_q;
      ser_load  = 1'b0;
      ser_line  = bus.dmem_rddata;
`ifdef DMEM_RD_PREFETCH_EN
      nxt_line_d = nxt_line_q;
      nxt_full_d = nxt_full_q;
      pf_done_d  = pf_done_q;
`endif

      if (rd_pend_q) begin
         if (rd_cap) begin
            rd_pend_d = 1'b0;
         end else begin
            lat_d = lat_q + 2'd1;
         end
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               if (line_cnt != '0) begin
                  addr_d  = base_addr;
                  rem_d   = line_cnt;
                  state_d = StFetch;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StFetch: begin
            rden_d    = 1'b1;
            rdaddr_d  = addr_q;
            rd_pend_d = 1'b1;
            lat_d     = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (rd_cap) begin
               ser_load = 1'b1;
               state_d  = StShift;
`ifdef DMEM_RD_PREFETCH_EN
               pf_done_d = 1'b0;
`endif
            end
         end
         StShift: begin
`ifdef DMEM_RD_PREFETCH_EN
            if (!pf_done_q && (rem_q > RemOne)) begin
               rden_d    = 1'b1;
               rdaddr_d  = addr_q + ADDR_W'(1);
               rd_pend_d = 1'b1;
               lat_d     = '0;
               pf_done_d = 1'b1;
            end
            if (rd_cap) begin
               nxt_line_d = bus.dmem_rddata;
               nxt_full_d = 1'b1;
            end
`endif
            if (word_done) begin
               if (rem_q == RemOne) begin
                  rem_d   = '0;
                  state_d = StFin;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  rem_d  = rem_q - RemOne;
`ifdef DMEM_RD_PREFETCH_EN
                  pf_done_d  = 1'b0;
                  nxt_full_d = 1'b0;
                  if (nxt_full_q) begin
                     ser_load = 1'b1;
                     ser_line = nxt_line_q;
                  end else if (rd_cap) begin
                     ser_load = 1'b1;
                  end else begin
                     state_d = StWait;
                  end
`else
                  state_d = StFetch;
`endif
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         rem_q     <= '0;
         rden_q    <= 1'b0;
         rdaddr_q  <= '0;
         rd_pend_q <= 1'b0;
         lat_q     <= '0;
`ifdef DMEM_RD_PREFETCH_EN
         nxt_line_q <= '0;
         nxt_full_q <= 1'b0;
         pf_done_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         rden_q    <= rden_d;
         rdaddr_q  <= rdaddr_d;
         rd_pend_q <= rd_pend_d;
         lat_q     <= lat_d;
`ifdef DMEM_RD_PREFETCH_EN
         nxt_line_q <= nxt_line_d;
         nxt_full_q <= nxt_full_d;
         pf_done_q  <= pf_done_d;
`endif
      end
   end

   line_serializer #(
      .LINE_W (LINE_W),
      .WORD_W (WORD_W),
      .IDX_W  (IdxW)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .line      (ser_line),
      .valid     (ser_valid),
      .data      (ser_data),
      .ready     (bus.out_ready),
      .idx       (ser_idx),
      .last_word (ser_last_word)
   );

   assign busy            = (state_q != StIdle);
   assign done            = (state_q == StFin);
   assign bus.dmem_rden   = rden_q;
   assign bus.dmem_rdaddr = rdaddr_q;
   assign bus.out_valid   = ser_valid;
   assign bus.out_data    = ser_data;
   assign bus.out_last    = ser_valid && (ser_idx == LastIdx) && (rem_q == RemOne);

endmodule

// File: tb/tb_dmem_line_reader.sv
// Directed bench for dmem_line_reader with a latency-1 DMEM port-B model.
module tb_dmem_line_reader;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned LINE_W = 256;
   localparam int unsigned WORD_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   line_cnt = '0;
   logic              busy;
   logic              done;

   dmem_line_reader_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) bus_if ();

   dmem_line_reader #(
      .ADDR_W     (ADDR_W),
      .LINE_W     (LINE_W),
      .WORD_W     (WORD_W),
      .RD_LATENCY (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .line_cnt  (line_cnt),
      .busy      (busy),
      .done      (done),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t0 = 0;
   int valid_cnt = 0;
   int rd_cyc[$];
   int rd_addr[$];
   int w_data[$];
   int w_cyc[$];
   int w_last[$];
   int done_cyc[$];
   int done_busy[$];
   logic [3:0] bp_pat = 4'b1001;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Word k of line a: high byte a^5, low byte k, so line 5 is 0x0000..0x000F.
   function automatic logic [15:0] wexp(input int a, input int k);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'(a ^ 5);
      lo = 8'(k);
      return {hi, lo};
   endfunction

   function automatic logic [LINE_W-1:0] mkline(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      for (int k = 0; k < 16; k++) l[k*16 +: 16] = wexp(int'(a), k);
      return l;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      bus_if.dmem_rddata <= bus_if.dmem_rden ? mkline(bus_if.dmem_rdaddr) : {16{16'hBAD0}};
   end

   initial begin
      logic        pv = 1'b0;
      logic        pr = 1'b0;
      logic [15:0] pd = '0;
      logic        pl = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.dmem_rden) begin
            rd_cyc.push_back(cyc - t0);
            rd_addr.push_back(int'(bus_if.dmem_rdaddr));
         end
         if (bus_if.out_valid) valid_cnt++;
         if (bus_if.out_valid && bus_if.out_ready) begin
            w_data.push_back(int'(bus_if.out_data));
            w_cyc.push_back(cyc - t0);
            w_last.push_back(int'(bus_if.out_last));
         end
         if (done) begin
            done_cyc.push_back(cyc - t0);
            done_busy.push_back(int'(busy));
         end
         if (pv && !pr) begin
            check("stall_valid", 32'(bus_if.out_valid), 32'd1);
            check("stall_data", 32'(bus_if.out_data), 32'(pd));
            check("stall_last", 32'(bus_if.out_last), 32'(pl));
         end
         pv = bus_if.out_valid;
         pr = bus_if.out_ready;
         pd = bus_if.out_data;
         pl = bus_if.out_last;
      end
   end

   task automatic clr();
      rd_cyc.delete();
      rd_addr.delete();
      w_data.delete();
      w_cyc.delete();
      w_last.delete();
      done_cyc.delete();
      done_busy.delete();
      valid_cnt = 0;
   endtask

   // Start is sampled at the returned edge, which becomes cycle 0.
   task automatic go(input int b, input int n);
      @(negedge clk);
      start     = 1'b1;
      base_addr = ADDR_W'(b);
      line_cnt  = (ADDR_W+1)'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
   endtask

   task automatic wait_done(input int budget, input bit bp);
      int i;
      i = 0;
      while (done_cyc.size() == 0 && i < budget) begin
         @(posedge clk);
         #1;
         if (bp) bus_if.out_ready = bp_pat[i % 4];
         i++;
      end
      bus_if.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("done_once", 32'(done_cyc.size()), 32'd1);
   endtask

   task automatic chk_reads(input int a0, input int n);
      check("rd_count", 32'(rd_addr.size()), 32'(n));
      for (int i = 0; i < n && i < rd_addr.size(); i++)
         check("rd_addr", 32'(rd_addr[i]), 32'((a0 + i) % 128));
   endtask

   // c0 < 0 skips cycle checks; gap is the idle cycles between lines.
   task automatic chk_stream(input int a0, input int nl, input int c0, input int gap);
      int j;
      check("word_count", 32'(w_data.size()), 32'(nl * 16));
      for (int l = 0; l < nl; l++) begin
         for (int k = 0; k < 16; k++) begin
            j = l * 16 + k;
            if (j < w_data.size()) begin
               check("word_data", 32'(w_data[j]), 32'(wexp((a0 + l) % 128, k)));
               check("word_last", 32'(w_last[j]), 32'(j == nl * 16 - 1));
               if (c0 >= 0) check("word_cycle", 32'(w_cyc[j]), 32'(c0 + l * (16 + gap) + k));
            end
         end
      end
   endtask

   initial begin
      int i;
      bus_if.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rden", 32'(bus_if.dmem_rden), 32'd0);
      check("rst_valid", 32'(bus_if.out_valid), 32'd0);
      check("rst_data", 32'(bus_if.out_data), 32'd0);
      rst = 1'b0;

      // Single line, exact timing.
      clr();
      go(5, 1);
      check("busy_start", 32'(busy), 32'd1);
      wait_done(100, 1'b0);
      chk_reads(5, 1);
      if (rd_cyc.size() > 0) check("rd_cycle", 32'(rd_cyc[0]), 32'd1);
      chk_stream(5, 1, 3, 0);
      if (done_cyc.size() > 0) begin
         check("done_cycle", 32'(done_cyc[0]), 32'd19);
         check("done_busy", 32'(done_busy[0]), 32'd1);
      end
      check("busy_after", 32'(busy), 32'd0);

      // Two lines: bubble timing, or gap-free with prefetch.
      clr();
      go(5, 2);
      wait_done(200, 1'b0);
      chk_reads(5, 2);
`ifdef DMEM_RD_PREFETCH_EN
      chk_stream(5, 2, 3, 0);
      if (done_cyc.size() > 0) check("done_cycle2", 32'(done_cyc[0]), 32'd35);
`else
      chk_stream(5, 2, 3, 3);
      if (done_cyc.size() > 0) check("done_cycle2", 32'(done_cyc[0]), 32'd38);
`endif

      // Address wrap.
      clr();
      go(126, 3);
      wait_done(300, 1'b0);
      chk_reads(126, 3);
      chk_stream(126, 3, -1, 0);

      // Backpressure 1,0,0,1.
      clr();
      go(5, 1);
      wait_done(300, 1'b1);
      chk_stream(5, 1, -1, 0);
      check("bp_stalled", 32'(valid_cnt > 16), 32'd1);

      // Zero-length request.
      clr();
      go(0, 0);
      check("zero_busy", 32'(busy), 32'd1);
      check("zero_done", 32'(done), 32'd1);
      wait_done(20, 1'b0);
      if (done_cyc.size() > 0) check("zero_done_cycle", 32'(done_cyc[0]), 32'd0);
      check("zero_rd", 32'(rd_cyc.size()), 32'd0);
      check("zero_valid", 32'(valid_cnt), 32'd0);
      check("zero_busy_after", 32'(busy), 32'd0);

      // Start while busy is ignored.
      clr();
      go(20, 2);
      repeat (10) @(negedge clk);
      start     = 1'b1;
      base_addr = 7'd40;
      line_cnt  = 8'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(300, 1'b0);
      chk_reads(20, 2);
      chk_stream(20, 2, -1, 0);

      // Asynchronous reset during line 2 of 3.
      clr();
      go(60, 3);
      i = 0;
      while (w_data.size() < 20 && i < 200) begin
         @(negedge clk);
         i++;
      end
      check("mid_reached", 32'(w_data.size() >= 20), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rden", 32'(bus_if.dmem_rden), 32'd0);
      check("arst_addr", 32'(bus_if.dmem_rdaddr), 32'd0);
      check("arst_valid", 32'(bus_if.out_valid), 32'd0);
      check("arst_data", 32'(bus_if.out_data), 32'd0);
      check("arst_last", 32'(bus_if.out_last), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("arst_no_done", 32'(done_cyc.size()), 32'd0);
      clr();
      go(10, 1);
      wait_done(100, 1'b0);
      chk_reads(10, 1);
      chk_stream(10, 1, 3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
